// File: rtl/mc_tap_delay_line.sv
// Multi-channel, time-multiplexed FIR tap delay line. Each accepted sample shifts into its
// channel's tap history, and the channel's full tap vector is emitted once per DECIM samples.
module mc_tap_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TAPS   = 8,
    parameter int NUM_CH     = 4,
    parameter int DECIM      = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   in_data,
    input  logic        [CH_W-1:0]         in_ch,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps,
    output logic [CH_W-1:0]                out_ch,
    output logic                           out_primed,
    output logic                           err_ch
);

    localparam int FILL_W = $clog2(NUM_TAPS + 1);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_TAPS);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(DECIM - 1);

    // The oldest tap is never stored: it falls off on the next shift, and the emitted
    // vector is always built from the post-shift history plus the incoming sample.
    logic signed [DATA_WIDTH-1:0] tap_q  [NUM_CH][NUM_TAPS-1];
    logic        [FILL_W-1:0]     fill_q [NUM_CH];
    logic        [PH_W-1:0]       ph_q   [NUM_CH];

    logic                           accept;
    logic                           ch_ok;
    logic                           emit;
    logic                           primed;
    logic [FILL_W-1:0]              sel_fill;
    logic [FILL_W-1:0]              new_fill;
    logic [PH_W-1:0]                sel_ph;
    logic signed [DATA_WIDTH-1:0]   sel_taps [NUM_TAPS-1];
    logic signed [DATA_WIDTH-1:0]   new_taps [NUM_TAPS];
    logic [NUM_TAPS*DATA_WIDTH-1:0] new_flat;

    assign in_ready = ~rst & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign ch_ok    = {1'b0, in_ch} < (CH_W + 1)'(NUM_CH);

    // NOTE: every always_comb output gets a default before any conditional assignment,
    // otherwise an unmatched channel index would infer a latch.
    always_comb begin
        sel_fill = '0;
        sel_ph   = '0;
        for (int k = 0; k < NUM_TAPS - 1; k++) sel_taps[k] = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
                sel_fill = fill_q[c];
                sel_ph   = ph_q[c];
                for (int k = 0; k < NUM_TAPS - 1; k++) sel_taps[k] = tap_q[c][k];
            end
        end
    end

    always_comb begin
        new_taps[0] = in_data;
        for (int k = 1; k < NUM_TAPS; k++) new_taps[k] = sel_taps[k-1];
        new_flat = '0;
        for (int k = 0; k < NUM_TAPS; k++) new_flat[k*DATA_WIDTH +: DATA_WIDTH] = new_taps[k];
    end

    assign new_fill = (sel_fill == FILL_MAX) ? FILL_MAX : sel_fill + FILL_W'(1);
    assign primed   = (new_fill == FILL_MAX);
    assign emit     = accept & ch_ok & (sel_ph == PH_LAST);

    // NOTE: the tap store is a register file rather than a RAM because flush must clear
    // every entry in one cycle, so it is reset explicitly like any other state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                fill_q[c] <= '0;
                ph_q[c]   <= '0;
                for (int k = 0; k < NUM_TAPS - 1; k++) tap_q[c][k] <= '0;
            end
        end else if (accept && ch_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_ch == CH_W'(c)) begin
                    for (int k = 0; k < NUM_TAPS - 1; k++) tap_q[c][k] <= new_taps[k];
                    fill_q[c] <= new_fill;
                    ph_q[c]   <= (sel_ph == PH_LAST) ? '0 : sel_ph + PH_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_taps   <= '0;
            out_ch     <= '0;
            out_primed <= 1'b0;
            err_ch     <= 1'b0;
        end else begin
            err_ch <= accept & ~ch_ok;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (emit) begin
                out_valid  <= 1'b1;
                out_taps   <= new_flat;
                out_ch     <= in_ch;
                out_primed <= primed;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mc_tap_delay_line.sv
// Scoreboard bench: two delay lines (DECIM=1 and DECIM=3) share one stimulus stream and
// are checked against a per-channel sample-history model.
module tb_mc_tap_delay_line;

    localparam int DW   = 8;
    localparam int NT   = 4;
    localparam int NCH  = 3;
    localparam int CHW  = 2;
    localparam int DEC0 = 1;
    localparam int DEC1 = 3;

    typedef struct {
        logic [NT*DW-1:0] taps;
        logic [CHW-1:0]   ch;
        logic             primed;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic [CHW-1:0]  in_ch;
    logic            out_ready;
    logic [1:0]      in_ready;
    logic [1:0]      out_valid;
    logic [1:0]      out_primed;
    logic [1:0]      err_ch;
    logic [NT*DW-1:0] out_taps [2];
    logic [CHW-1:0]  out_ch [2];

    vec_t            exp_q [2][$];
    logic [DW-1:0]   hist [2][NCH][$];
    bit              mv [2];
    bit              exp_err [2];
    int              n_out [2];
    bit              armed = 1'b0;
    int              n_checks = 0;
    int              n_pass = 0;

    always #5 clk = ~clk;

    mc_tap_delay_line #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .NUM_CH(NCH), .DECIM(DEC0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_taps(out_taps[0]), .out_ch(out_ch[0]), .out_primed(out_primed[0]),
        .err_ch(err_ch[0])
    );

    mc_tap_delay_line #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .NUM_CH(NCH), .DECIM(DEC1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_taps(out_taps[1]), .out_ch(out_ch[1]), .out_primed(out_primed[1]),
        .err_ch(err_ch[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model, evaluated once per cycle with the inputs the next edge will sample.
    task automatic model_step(input int d);
        int  dec;
        int  n;
        bit  rdy;
        bit  emit;
        vec_t v;
        dec = (d == 0) ? DEC0 : DEC1;
        if (rst || flush) begin
            check($sformatf("in_ready_blocked[%0d]", d), 64'(in_ready[d]), 64'(0));
            for (int c = 0; c < NCH; c++) hist[d][c].delete();
            exp_q[d].delete();
            mv[d]      = 1'b0;
            exp_err[d] = 1'b0;
            return;
        end
        rdy = !mv[d] || out_ready;
        check($sformatf("in_ready[%0d]", d), 64'(in_ready[d]), 64'(rdy));
        emit       = 1'b0;
        exp_err[d] = 1'b0;
        if (in_valid && rdy) begin
            if (int'(in_ch) >= NCH) begin
                exp_err[d] = 1'b1;
            end else begin
                hist[d][in_ch].push_back(in_data);
                n = hist[d][in_ch].size();
                if (n % dec == 0) begin
                    v.taps = '0;
                    for (int k = 0; k < NT; k++)
                        if (k < n) v.taps[k*DW +: DW] = hist[d][in_ch][n-1-k];
                    v.ch     = in_ch;
                    v.primed = (n >= NT);
                    exp_q[d].push_back(v);
                    emit = 1'b1;
                end
            end
        end
        if (emit) mv[d] = 1'b1;
        else if (out_ready) mv[d] = 1'b0;
    endtask

    task automatic monitor(input int d);
        bit   expv;
        vec_t v;
        expv = (exp_q[d].size() != 0);
        check($sformatf("out_valid[%0d]", d), 64'(out_valid[d]), 64'(expv));
        check($sformatf("err_ch[%0d]", d), 64'(err_ch[d]), 64'(exp_err[d]));
        if (expv) begin
            v = exp_q[d][0];
            if (out_valid[d]) begin
                check($sformatf("out_taps[%0d]", d), 64'(out_taps[d]), 64'(v.taps));
                check($sformatf("out_ch[%0d]", d), 64'(out_ch[d]), 64'(v.ch));
                check($sformatf("out_primed[%0d]", d), 64'(out_primed[d]), 64'(v.primed));
            end
            if (out_ready) begin
                void'(exp_q[d].pop_front());
                n_out[d]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) for (int d = 0; d < 2; d++) monitor(d);
    end

    always @(negedge clk) begin
        #1;
        if (armed) for (int d = 0; d < 2; d++) model_step(d);
    end

    task automatic cyc(input bit v, input logic [DW-1:0] dat, input logic [CHW-1:0] ch,
                       input bit rdy);
        in_valid  = v;
        in_data   = dat;
        in_ch     = ch;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(1'b1, 8'hAA, 2'd0, 1'b1);
        flush = 1'b0;
    endtask

    initial begin
        int s0;
        int s1;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        armed = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_taps[%0d]", d), 64'(out_taps[d]), 64'(0));
            check($sformatf("rst_ch[%0d]", d), 64'(out_ch[d]), 64'(0));
            check($sformatf("rst_primed[%0d]", d), 64'(out_primed[d]), 64'(0));
        end
        rst = 1'b0;
        cyc(1'b0, 8'd0, 2'd0, 1'b1);

        // Impulse on ch0.
        cyc(1'b1, 8'd1, 2'd0, 1'b1);
        repeat (4) cyc(1'b1, 8'd0, 2'd0, 1'b1);
        cyc(1'b0, 8'd0, 2'd0, 1'b1);

        // Interleaved channels with negative samples.
        do_flush();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'(10 + i), 2'd0, 1'b1);
            cyc(1'b1, 8'(-(i + 1)), 2'd1, 1'b1);
        end
        cyc(1'b0, 8'd0, 2'd0, 1'b1);

        // Backpressure: stall for 5 clocks with a sample waiting, then release.
        cyc(1'b1, 8'd5, 2'd0, 1'b1);
        repeat (5) cyc(1'b1, 8'd6, 2'd0, 1'b0);
        cyc(1'b1, 8'd6, 2'd0, 1'b1);
        cyc(1'b0, 8'd0, 2'd0, 1'b1);
        cyc(1'b0, 8'd0, 2'd0, 1'b1);

        // Decimation: 7 samples -> 7 vectors at DECIM=1, 2 vectors at DECIM=3.
        do_flush();
        s0 = n_out[0];
        s1 = n_out[1];
        for (int i = 1; i <= 7; i++) cyc(1'b1, 8'(i), 2'd0, 1'b1);
        repeat (2) cyc(1'b0, 8'd0, 2'd0, 1'b1);
        check("decim1_count", 64'(n_out[0] - s0), 64'(7));
        check("decim3_count", 64'(n_out[1] - s1), 64'(2));

        // Flush, then reset, with a vector pending on ch1.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 2'd1, 1'b1);
            if (pass == 0) flush = 1'b1;
            else rst = 1'b1;
            cyc(1'b1, 8'd7, 2'd1, 1'b0);
            flush = 1'b0;
            rst   = 1'b0;
            check($sformatf("drop_valid0_p%0d", pass), 64'(out_valid[0]), 64'(0));
            cyc(1'b1, 8'd9, 2'd1, 1'b1);
            cyc(1'b0, 8'd0, 2'd0, 1'b1);
        end

        // Out-of-range channel.
        cyc(1'b1, 8'h55, 2'd3, 1'b1);
        check("err_pulse0", 64'(err_ch[0]), 64'(1));
        check("err_pulse1", 64'(err_ch[1]), 64'(1));
        cyc(1'b0, 8'd0, 2'd0, 1'b1);
        check("err_clear0", 64'(err_ch[0]), 64'(0));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            flush = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 9) < 7, 8'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0);
        end
        flush = 1'b0;
        rst   = 1'b0;
        repeat (5) cyc(1'b0, 8'd0, 2'd0, 1'b1);
        for (int d = 0; d < 2; d++)
            check($sformatf("drained[%0d]", d), 64'(exp_q[d].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
